// File: rtl/play_pkg.sv
// Shared types and constants for the play_sched keyboard/song display scheduler.
package play_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MANUAL,
    HOLDOFF,
    AUTO_PLAY,
    AUTO_GAP
  } state_t;

  localparam logic [2:0] KEY_NONE = 3'd7;
  localparam logic [1:0] TONE_OFF = 2'b00;

  // Song entry layout: {tone[7:6], note[5:3], dur[2:0]}
  localparam int ROM_TONE_HI = 7;
  localparam int ROM_TONE_LO = 6;
  localparam int ROM_NOTE_HI = 5;
  localparam int ROM_NOTE_LO = 3;
  localparam int ROM_DUR_HI  = 2;
  localparam int ROM_DUR_LO  = 0;

endpackage

// File: rtl/play_sched_if.sv
// Key/switch inputs and lattice/buzzer outputs of play_sched, grouped as one bundle.
interface play_sched_if;
  logic [6:0] key_in;
  logic [1:0] tone_sw;
  logic       play_start;
  logic       play_stop;
  logic [2:0] unable;
  logic [1:0] tone;
  logic       note_valid;
  logic       src_auto;
  logic [7:0] song_idx;
  logic       song_done;

  modport master (
    output key_in, tone_sw, play_start, play_stop,
    input  unable, tone, note_valid, src_auto, song_idx, song_done
  );

  modport slave (
    input  key_in, tone_sw, play_start, play_stop,
    output unable, tone, note_valid, src_auto, song_idx, song_done
  );
endinterface

// File: rtl/play_sched_song_rom.sv
// Song table for the auto-play sequencer; pure combinational lookup, unused addresses read as a 1-beat rest.
module song_rom (
  input  logic [7:0] i_addr,
  output logic [7:0] o_entry
);
  always_comb begin
    case (i_addr)
      8'd0:    o_entry = 8'h81;
      8'd1:    o_entry = 8'h4A;
      8'd2:    o_entry = 8'hF8;
      8'd3:    o_entry = 8'h90;
      8'd4:    o_entry = 8'hA0;
      8'd5:    o_entry = 8'hB1;
      8'd6:    o_entry = 8'h58;
      8'd7:    o_entry = 8'h60;
      8'd8:    o_entry = 8'h69;
      8'd9:    o_entry = 8'hF8;
      8'd10:   o_entry = 8'h88;
      8'd11:   o_entry = 8'h98;
      8'd12:   o_entry = 8'hA8;
      8'd13:   o_entry = 8'hB0;
      8'd14:   o_entry = 8'h40;
      8'd15:   o_entry = 8'hF9;
      default: o_entry = 8'hF8;
    endcase
  end
endmodule

// File: rtl/play_sched.sv
// Shares the lattice display and note path between live keys (always preempting) and the song sequencer.
// Optional feature macro SONG_LOOP_EN: repeat the song from entry 0 until play_stop.
module play_sched
  import play_pkg::*;
#(
  parameter int BEAT_DIV   = 50000,
  parameter int HOLD_BEATS = 4,
  parameter int SONG_LEN   = 16
) (
  input  logic        sysclk,
  input  logic        rst,
  play_sched_if.slave bus
);
  localparam int BW = $clog2(BEAT_DIV);
  localparam int HW = (HOLD_BEATS > 1) ? $clog2(HOLD_BEATS) : 1;

  state_t      r_state;
  logic [6:0]  r_key_q;
  logic [BW-1:0] r_beat_cnt;
  logic [2:0]  r_dur_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic        r_paused;
  logic [7:0]  r_song_idx;
  logic [2:0]  r_unable;
  logic [1:0]  r_tone;
  logic        r_note_valid;
  logic        r_src_auto;
  logic        r_song_done;

  state_t      w_state_nxt;
  logic [7:0]  w_idx_nxt;
  logic        w_paused_nxt;
  logic        w_done_nxt;
  logic [2:0]  w_unable_nxt;
  logic [1:0]  w_tone_nxt;
  logic        w_note_valid_nxt;
  logic        w_src_auto_nxt;
  logic [7:0]  w_rom;
  logic [7:0]  w_idx_inc;
  logic [2:0]  w_key_enc;
  logic        w_manual_req;
  logic        w_tick;
  logic        w_idx_last;
  logic        w_hold_last;
  logic        w_enter;

  assign w_manual_req = |r_key_q;
  assign w_tick       = (r_beat_cnt == BW'(BEAT_DIV - 1));
  assign w_idx_last   = (r_song_idx == 8'(SONG_LEN - 1));
  assign w_idx_inc    = w_idx_last ? 8'd0 : r_song_idx + 8'd1;
  assign w_hold_last  = (r_hold_cnt == HW'(HOLD_BEATS - 1));
  assign w_enter      = (w_state_nxt != r_state);

  // The ROM is addressed with the entry about to be shown so outputs and dur load line up.
  song_rom u_song_rom (
    .i_addr  (w_idx_nxt),
    .o_entry (w_rom)
  );

  // Lowest pressed key wins.
  always_comb begin
    w_key_enc = KEY_NONE;
    for (int k = 6; k >= 0; k--) begin
      if (r_key_q[k]) w_key_enc = 3'(k);
    end
  end

  // State register plus registered outputs.
  always_ff @(posedge sysclk) begin
    // NOTE: every clocked assignment is non-blocking so all registers see pre-edge values.
    if (rst) begin
      r_state      <= IDLE;
      r_key_q      <= '0;
      r_paused     <= 1'b0;
      r_song_idx   <= '0;
      r_unable     <= KEY_NONE;
      r_tone       <= TONE_OFF;
      r_note_valid <= 1'b0;
      r_src_auto   <= 1'b0;
      r_song_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_key_q      <= bus.key_in;
      r_paused     <= w_paused_nxt;
      r_song_idx   <= w_idx_nxt;
      r_unable     <= w_unable_nxt;
      r_tone       <= w_tone_nxt;
      r_note_valid <= w_note_valid_nxt;
      r_src_auto   <= w_src_auto_nxt;
      r_song_done  <= w_done_nxt;
    end
  end

  // Beat, duration and hold-off counters; each restarts on entry to the state that times with it.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_dur_cnt  <= '0;
      r_hold_cnt <= '0;
    end else begin
      if (w_enter && (w_state_nxt inside {AUTO_PLAY, AUTO_GAP, HOLDOFF})) r_beat_cnt <= '0;
      else if (w_tick)                                                    r_beat_cnt <= '0;
      else                                                                r_beat_cnt <= r_beat_cnt + 1'b1;

      if (w_enter && w_state_nxt == AUTO_PLAY)          r_dur_cnt <= w_rom[ROM_DUR_HI:ROM_DUR_LO];
      else if (r_state == AUTO_PLAY && w_tick && r_dur_cnt != 3'd0) r_dur_cnt <= r_dur_cnt - 3'd1;

      if (w_enter && w_state_nxt == HOLDOFF)  r_hold_cnt <= '0;
      else if (r_state == HOLDOFF && w_tick)  r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  // Next-state logic; priority is play_stop > manual_req > play_start > tick.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    w_state_nxt  = r_state;
    w_idx_nxt    = r_song_idx;
    w_paused_nxt = r_paused;
    w_done_nxt   = 1'b0;
    if (bus.play_stop) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_manual_req) w_state_nxt = MANUAL;
          else if (bus.play_start) begin
            w_state_nxt = AUTO_PLAY;
            w_idx_nxt   = 8'd0;
          end
        end
        MANUAL: begin
          if (!w_manual_req) w_state_nxt = r_paused ? HOLDOFF : IDLE;
        end
        HOLDOFF: begin
          if (w_manual_req)              w_state_nxt = MANUAL;
          else if (w_tick && w_hold_last) w_state_nxt = AUTO_PLAY;
        end
        AUTO_PLAY: begin
          if (w_manual_req) begin
            w_state_nxt  = MANUAL;
            w_paused_nxt = 1'b1;
          end else if (w_tick && r_dur_cnt == 3'd0) begin
            w_state_nxt = AUTO_GAP;
          end
        end
        AUTO_GAP: begin
          if (w_manual_req) begin
            w_state_nxt = MANUAL;
            w_idx_nxt   = w_idx_inc;
            w_done_nxt  = w_idx_last;
`ifdef SONG_LOOP_EN
            w_paused_nxt = 1'b1;
`else
            w_paused_nxt = !w_idx_last;
`endif
          end else if (w_tick) begin
            w_idx_nxt  = w_idx_inc;
            w_done_nxt = w_idx_last;
`ifdef SONG_LOOP_EN
            w_state_nxt = AUTO_PLAY;
`else
            w_state_nxt = w_idx_last ? IDLE : AUTO_PLAY;
            if (w_idx_last) w_idx_nxt = r_song_idx;
`endif
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    if (w_state_nxt == IDLE) w_paused_nxt = 1'b0;
  end

  // Output decode from the state being entered, so outputs change on the same edge as the state.
  always_comb begin
    w_unable_nxt     = KEY_NONE;
    w_tone_nxt       = TONE_OFF;
    w_note_valid_nxt = 1'b0;
    w_src_auto_nxt   = 1'b0;
    case (w_state_nxt)
      MANUAL: begin
        w_unable_nxt     = w_key_enc;
        w_tone_nxt       = bus.tone_sw;
        w_note_valid_nxt = 1'b1;
      end
      AUTO_PLAY: begin
        w_unable_nxt     = w_rom[ROM_NOTE_HI:ROM_NOTE_LO];
        w_tone_nxt       = w_rom[ROM_TONE_HI:ROM_TONE_LO];
        w_note_valid_nxt = (w_rom[ROM_NOTE_HI:ROM_NOTE_LO] != KEY_NONE);
        w_src_auto_nxt   = 1'b1;
      end
      AUTO_GAP: w_src_auto_nxt = 1'b1;
      default: ;
    endcase
  end

  assign bus.unable     = r_unable;
  assign bus.tone       = r_tone;
  assign bus.note_valid = r_note_valid;
  assign bus.src_auto   = r_src_auto;
  assign bus.song_idx   = r_song_idx;
  assign bus.song_done  = r_song_done;

endmodule

// File: tb/tb_play_sched.sv
// Directed bench for play_sched with BEAT_DIV=4, HOLD_BEATS=2, SONG_LEN=3 (ROM 81, 4A, F8).
module tb_play_sched;
  logic sysclk = 1'b0;
  logic rst;

  play_sched_if bus ();

  play_sched #(
    .BEAT_DIV   (4),
    .HOLD_BEATS (2),
    .SONG_LEN   (3)
  ) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_errors = 0;

  // Packed view: {song_done, src_auto, note_valid, tone, unable, song_idx}
  function automatic logic [15:0] pk(input logic [2:0] u, input logic [1:0] t, input logic nv,
                                     input logic sa, input logic sd, input logic [7:0] idx);
    return {sd, sa, nv, t, u, idx};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.song_done, bus.src_auto, bus.note_valid, bus.tone, bus.unable, bus.song_idx};
  endfunction

  // Expected output i cycles after play_start is taken, for an uninterrupted song.
  function automatic logic [15:0] song_exp(input int i);
    if (i < 8)       return pk(3'd0, 2'b10, 1'b1, 1'b1, 1'b0, 8'd0);
    else if (i < 12) return pk(3'd7, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
    else if (i < 24) return pk(3'd1, 2'b01, 1'b1, 1'b1, 1'b0, 8'd1);
    else if (i < 28) return pk(3'd7, 2'b00, 1'b0, 1'b1, 1'b0, 8'd1);
    else if (i < 32) return pk(3'd7, 2'b11, 1'b0, 1'b1, 1'b0, 8'd2);
    else             return pk(3'd7, 2'b00, 1'b0, 1'b1, 1'b0, 8'd2);
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic start_song();
    bus.play_start = 1'b1;
    step();
    bus.play_start = 1'b0;
  endtask

  task automatic stop_song();
    bus.play_stop = 1'b1;
    step();
    bus.play_stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.key_in     = 7'd0;
    bus.tone_sw    = 2'b11;
    bus.play_start = 1'b0;
    bus.play_stop  = 1'b0;
    step();
    step();
    check("reset", obs(), pk(3'd7, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0));
    rst = 1'b0;

    // Manual play: 2-edge latency, lowest set key wins, idle 2 edges after release
    bus.key_in = 7'b0000100;
    step();
    check("key_lat1", obs(), pk(3'd7, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0));
    step();
    check("key2", obs(), pk(3'd2, 2'b11, 1'b1, 1'b0, 1'b0, 8'd0));
    bus.key_in = 7'b0110000;
    step();
    step();
    check("key4_lowest", obs(), pk(3'd4, 2'b11, 1'b1, 1'b0, 1'b0, 8'd0));
    bus.key_in = 7'd0;
    step();
    check("release_lat1", obs(), pk(3'd4, 2'b11, 1'b1, 1'b0, 1'b0, 8'd0));
    step();
    check("release_idle", obs(), pk(3'd7, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0));

    // Full uninterrupted song: 36 cycles then song_done
    start_song();
    for (int i = 0; i < 36; i++) begin
      check($sformatf("song_c%0d", i), obs(), song_exp(i));
      step();
    end
`ifdef SONG_LOOP_EN
    check("song_end_loop", obs(), pk(3'd0, 2'b10, 1'b1, 1'b1, 1'b1, 8'd0));
    step();
    check("song_loop_c1", obs(), pk(3'd0, 2'b10, 1'b1, 1'b1, 1'b0, 8'd0));
`else
    check("song_end", obs() & 16'hFF00, pk(3'd7, 2'b00, 1'b0, 1'b0, 1'b1, 8'd0) & 16'hFF00);
    step();
    check("song_end_c1", obs() & 16'hFF00, pk(3'd7, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0) & 16'hFF00);
`endif
    stop_song();
    check("stop_idle", obs(), pk(3'd7, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0));

    // Preempt in entry 1, hold-off of 8 cycles, then entry 1 replays in full
    start_song();
    for (int i = 1; i <= 14; i++) step();
    check("pre_entry1", obs(), pk(3'd1, 2'b01, 1'b1, 1'b1, 1'b0, 8'd1));
    bus.key_in = 7'b0000001;
    step();
    check("pre_lat1", obs(), pk(3'd1, 2'b01, 1'b1, 1'b1, 1'b0, 8'd1));
    step();
    check("preempt", obs(), pk(3'd0, 2'b11, 1'b1, 1'b0, 1'b0, 8'd1));
    step();
    step();
    bus.key_in = 7'd0;
    step();
    check("pre_rel_lat1", obs(), pk(3'd0, 2'b11, 1'b1, 1'b0, 1'b0, 8'd1));
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("holdoff_c%0d", i), obs(), pk(3'd7, 2'b00, 1'b0, 1'b0, 1'b0, 8'd1));
    end
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("resume_c%0d", i), obs(), pk(3'd1, 2'b01, 1'b1, 1'b1, 1'b0, 8'd1));
    end
    step();
    check("resume_gap", obs(), pk(3'd7, 2'b00, 1'b0, 1'b1, 1'b0, 8'd1));
    stop_song();
    check("stop_gap", obs(), pk(3'd7, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0));

    // play_stop + play_start + key in one cycle: stop wins, then manual
    bus.tone_sw = 2'b01;
    start_song();
    for (int i = 1; i <= 13; i++) step();
    check("combo_pre", obs(), pk(3'd1, 2'b01, 1'b1, 1'b1, 1'b0, 8'd1));
    bus.play_start = 1'b1;
    bus.play_stop  = 1'b1;
    bus.key_in     = 7'b0001000;
    step();
    bus.play_start = 1'b0;
    bus.play_stop  = 1'b0;
    check("combo_stop", obs(), pk(3'd7, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0));
    step();
    check("combo_manual", obs(), pk(3'd3, 2'b01, 1'b1, 1'b0, 1'b0, 8'd0));
    bus.key_in = 7'd0;
    step();
    step();
    check("combo_idle", obs(), pk(3'd7, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0));
    bus.tone_sw = 2'b11;

    // Preempt in the last gap: song_done pulses, saved index wraps to 0
    start_song();
    for (int i = 1; i <= 32; i++) step();
    check("last_gap", obs(), pk(3'd7, 2'b00, 1'b0, 1'b1, 1'b0, 8'd2));
    bus.key_in = 7'b1000000;
    step();
    check("last_gap_lat1", obs(), pk(3'd7, 2'b00, 1'b0, 1'b1, 1'b0, 8'd2));
    step();
    check("last_gap_pre", obs(), pk(3'd6, 2'b11, 1'b1, 1'b0, 1'b1, 8'd0));
    step();
    check("last_gap_done_off", obs(), pk(3'd6, 2'b11, 1'b1, 1'b0, 1'b0, 8'd0));
    bus.key_in = 7'd0;
    step();
    step();
    check("last_gap_rel", obs(), pk(3'd7, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0));
    for (int i = 0; i < 8; i++) step();
`ifdef SONG_LOOP_EN
    check("last_gap_after", obs(), pk(3'd0, 2'b10, 1'b1, 1'b1, 1'b0, 8'd0));
`else
    check("last_gap_after", obs(), pk(3'd7, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0));
`endif
    stop_song();

    // Synchronous reset in the middle of AUTO_PLAY
    start_song();
    for (int i = 1; i <= 14; i++) step();
    check("rst_pre", obs(), pk(3'd1, 2'b01, 1'b1, 1'b1, 1'b0, 8'd1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_play", obs(), pk(3'd7, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0));
    step();
    check("rst_stays_idle", obs(), pk(3'd7, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
